// File: rtl/bru_pkg.sv
// Shared types and default sizing for the branch resolve unit.
// The entry struct is sized by the default widths below; the top-level
// width parameters are expected to keep these defaults.
package bru_pkg;

   localparam int unsigned DEF_INDEX_WIDTH = 6;
   localparam int unsigned DEF_ADDR_WIDTH  = 64;
   localparam int unsigned DEF_FIFO_DEPTH  = 4;

   // Resolve FSM: IDLE accepts resolves, REDIRECT waits for fetch to take the new PC.
   typedef enum logic [0:0] {
      ST_IDLE     = 1'b0,
      ST_REDIRECT = 1'b1
   } bru_state_e;

   // One in-flight prediction as recorded at fetch.
   typedef struct packed {
      logic                       taken;
      logic [DEF_INDEX_WIDTH-1:0] index;
      logic [DEF_ADDR_WIDTH-1:0]  target;
      logic [DEF_ADDR_WIDTH-1:0]  fallthrough;
   } bru_entry_t;

endpackage

// File: rtl/pred_fifo.sv
// In-order store of predicted branches awaiting resolution.
// Pointers are one bit wider than the address so full and empty are distinguishable.
module pred_fifo
   import bru_pkg::*;
#(
   parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
   input  logic       i_clk,
   input  logic       i_arst,
   input  logic       i_push,
   input  logic       i_pop,
   input  logic       i_clear,
   input  bru_entry_t i_data,
   output bru_entry_t o_head,
   output logic       o_full,
   output logic       o_empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned PW = AW + 1;

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   bru_entry_t    mem_q [DEPTH];
   logic          do_push;
   logic          do_pop;

   assign o_empty = (wr_ptr_q == rd_ptr_q);
   assign o_full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign o_head  = mem_q[rd_ptr_q[AW-1:0]];

   // Next pointer values: clear wins, otherwise advance on accepted push/pop.
   always_comb begin
      // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latch).
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      do_pop   = i_pop && !o_empty;
      // A full FIFO can still take a push when the head leaves in the same cycle.
      do_push  = i_push && (!o_full || do_pop);
      if (i_clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      end
   end

   // Pointer registers.
   always_ff @(posedge i_clk or posedge i_arst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (i_arst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Entry storage write.
   // NOTE: storage has no reset; contents are only visible through valid pointers.
   always_ff @(posedge i_clk) begin
      if (do_push && !i_clear) mem_q[wr_ptr_q[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Matches resolved branches against recorded predictions, trains the BHT,
// and requests a fetch redirect plus flush on a mispredict.
module branch_resolve_unit
   import bru_pkg::*;
#(
   parameter int unsigned INDEX_WIDTH = DEF_INDEX_WIDTH,
   parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
   input  logic                   i_clk,
   input  logic                   i_arst,
   input  logic                   i_pred_push,
   input  logic                   i_pred_taken,
   input  logic [INDEX_WIDTH-1:0] i_pred_index,
   input  logic [ADDR_WIDTH-1:0]  i_pred_target,
   input  logic [ADDR_WIDTH-1:0]  i_pred_fallthrough,
   output logic                   o_pred_full,
   input  logic                   i_resolve_valid,
   input  logic                   i_actual_taken,
   input  logic [ADDR_WIDTH-1:0]  i_actual_target,
   output logic                   o_bht_update,
   output logic                   o_branch_taken,
   output logic [INDEX_WIDTH-1:0] o_set_index_exec,
   output logic                   o_redirect_valid,
   output logic [ADDR_WIDTH-1:0]  o_redirect_pc,
   input  logic                   i_redirect_ready,
   output logic                   o_flush,
   output logic                   o_busy,
   output logic                   o_overflow,
   output logic                   o_underflow,
   output logic [31:0]            o_mispredict_count
);

   bru_state_e state_q, state_d;

   logic                   fifo_full, fifo_empty;
   bru_entry_t             head, push_entry;

   logic                   is_idle;
   logic                   resolve_acc;
   logic                   mispredict;
   logic                   push_ok;
   logic                   push_acc;
   logic                   overflow_evt;
   logic                   underflow_evt;

   logic                   update_q, update_d;
   logic                   taken_q, taken_d;
   logic [INDEX_WIDTH-1:0] index_q, index_d;
   logic                   flush_q, flush_d;
   logic [ADDR_WIDTH-1:0]  redirect_pc_q, redirect_pc_d;
   logic [31:0]            count_q, count_d;
   logic                   overflow_q, overflow_d;
   logic                   underflow_q, underflow_d;

   assign push_entry = '{taken:       i_pred_taken,
                         index:       i_pred_index,
                         target:      i_pred_target,
                         fallthrough: i_pred_fallthrough};

   pred_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_pred_fifo (
      .i_clk   (i_clk),
      .i_arst  (i_arst),
      .i_push  (push_acc),
      .i_pop   (resolve_acc),
      .i_clear (mispredict),
      .i_data  (push_entry),
      .o_head  (head),
      .o_full  (fifo_full),
      .o_empty (fifo_empty)
   );

   // Classify this cycle's resolve and push; wrong-path pushes are silently dropped.
   always_comb begin
      is_idle       = (state_q == ST_IDLE);
      resolve_acc   = i_resolve_valid && is_idle && !fifo_empty;
      underflow_evt = i_resolve_valid && is_idle && fifo_empty;
      mispredict    = resolve_acc &&
                      ((head.taken != i_actual_taken) ||
                       (head.taken && i_actual_taken && (i_actual_target != head.target)));
      push_ok       = i_pred_push && is_idle && !mispredict;
      push_acc      = push_ok && (!fifo_full || resolve_acc);
      overflow_evt  = push_ok && fifo_full && !resolve_acc;
   end

   // State register.
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next state: enter REDIRECT on a mispredict, leave once fetch accepts.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:     if (mispredict)       state_d = ST_REDIRECT;
         ST_REDIRECT: if (i_redirect_ready) state_d = ST_IDLE;
         default:                           state_d = ST_IDLE;
      endcase
   end

   // State-decoded outputs: redirect request doubles as the execute stall.
   always_comb begin
      o_redirect_valid = (state_q == ST_REDIRECT);
      o_busy           = (state_q == ST_REDIRECT);
   end

   // Next values for the training strobe, redirect capture, counter and sticky flags.
   always_comb begin
      update_d      = resolve_acc;
      flush_d       = mispredict;
      taken_d       = taken_q;
      index_d       = index_q;
      redirect_pc_d = redirect_pc_q;
      count_d       = count_q;
      overflow_d    = overflow_q | overflow_evt;
      underflow_d   = underflow_q | underflow_evt;
      if (resolve_acc) begin
         taken_d = i_actual_taken;
         index_d = head.index;
      end
      if (mispredict) begin
         redirect_pc_d = i_actual_taken ? i_actual_target : head.fallthrough;
         count_d       = count_q + 32'd1;
      end
   end

   // Datapath registers.
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         update_q      <= 1'b0;
         taken_q       <= 1'b0;
         index_q       <= '0;
         flush_q       <= 1'b0;
         redirect_pc_q <= '0;
         count_q       <= '0;
         overflow_q    <= 1'b0;
         underflow_q   <= 1'b0;
      end else begin
         update_q      <= update_d;
         taken_q       <= taken_d;
         index_q       <= index_d;
         flush_q       <= flush_d;
         redirect_pc_q <= redirect_pc_d;
         count_q       <= count_d;
         overflow_q    <= overflow_d;
         underflow_q   <= underflow_d;
      end
   end

   assign o_pred_full        = fifo_full;
   assign o_bht_update       = update_q;
   assign o_branch_taken     = taken_q;
   assign o_set_index_exec   = index_q;
   assign o_flush            = flush_q;
   assign o_redirect_pc      = redirect_pc_q;
   assign o_mispredict_count = count_q;
   assign o_overflow         = overflow_q;
   assign o_underflow        = underflow_q;

endmodule
